// File: rtl/mem_access_unit_pkg.sv
// Shared widths, load/store op codes, byte-enable constants and state/size
// encodings for the memory-access stage.
package mem_access_unit_pkg;

  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned ALU_OP_BUS   = 8;

  localparam logic [ALU_OP_BUS-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_BUS-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_BUS-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_BUS-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_BUS-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_BUS-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_BUS-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_BUS-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  // Byte offset forced to the natural alignment of the access size.
  function automatic logic [1:0] natural_offset(acc_size_e sz, logic [1:0] a);
    case (sz)
      SZ_BYTE: natural_offset = a;
      SZ_HALF: natural_offset = {a[1], 1'b0};
      default: natural_offset = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// mem_lsu_align: combinational op decode, byte-enable generation, store-data
// lane replication and load extraction with sign/zero extension.
module mem_lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [ALU_OP_BUS-1:0] aluop,
  input  logic [1:0]            addr_lo,
  input  logic [REG_BUS-1:0]    store_data,
  input  logic [REG_BUS-1:0]    rdata,
  output acc_size_e             size,
  output logic                  is_load,
  output logic                  is_store,
  output logic [3:0]            be,
  output logic [REG_BUS-1:0]    wdata,
  output logic [REG_BUS-1:0]    load_data
);

  logic                sext;
  logic [1:0]          off;
  logic [REG_BUS-1:0]  lane;

  always_comb begin
    size     = SZ_NONE;
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    case (aluop)
      EXE_LB_OP:  begin size = SZ_BYTE; is_load  = 1'b1; sext = 1'b1; end
      EXE_LBU_OP: begin size = SZ_BYTE; is_load  = 1'b1; end
      EXE_LH_OP:  begin size = SZ_HALF; is_load  = 1'b1; sext = 1'b1; end
      EXE_LHU_OP: begin size = SZ_HALF; is_load  = 1'b1; end
      EXE_LW_OP:  begin size = SZ_WORD; is_load  = 1'b1; end
      EXE_SB_OP:  begin size = SZ_BYTE; is_store = 1'b1; end
      EXE_SH_OP:  begin size = SZ_HALF; is_store = 1'b1; end
      EXE_SW_OP:  begin size = SZ_WORD; is_store = 1'b1; end
      default:    ;
    endcase
  end

  assign off  = natural_offset(size, addr_lo);
  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    if (is_load) begin
      be = BE_WORD;
      case (size)
        SZ_BYTE: load_data = {{24{sext & lane[7]}}, lane[7:0]};
        SZ_HALF: load_data = {{16{sext & lane[15]}}, lane[15:0]};
        SZ_WORD: load_data = rdata;
        default: load_data = '0;
      endcase
    end else if (is_store) begin
      case (size)
        SZ_BYTE: begin be = BE_BYTE << off; wdata = {4{store_data[7:0]}};  end
        SZ_HALF: begin be = BE_HALF << off; wdata = {2{store_data[15:0]}}; end
        SZ_WORD: begin be = BE_WORD;        wdata = store_data;            end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: req/ack data-bus FSM with stall request.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_BUS-1:0] mem_wd,
  input  logic                    mem_wreg,
  input  logic [REG_BUS-1:0]      mem_wdata,
  input  logic [ALU_OP_BUS-1:0]   mem_aluop,
  input  logic [REG_BUS-1:0]      mem_mem_addr,
  input  logic [REG_BUS-1:0]      mem_reg2,
  output logic [REG_ADDR_BUS-1:0] wb_wd,
  output logic                    wb_wreg,
  output logic [REG_BUS-1:0]      wb_wdata,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [REG_BUS-1:0]      dbus_addr,
  output logic [3:0]              dbus_be,
  output logic [REG_BUS-1:0]      dbus_wdata,
  input  logic [REG_BUS-1:0]      dbus_rdata,
  input  logic                    dbus_ack,
  output logic                    stallreq_mem
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                    align_err
`endif
);

  state_e             state;
  acc_size_e          size;
  logic               is_load;
  logic               is_store;
  logic               is_mem;
  logic               align_fault;
  logic [3:0]         be_c;
  logic [REG_BUS-1:0] wdata_c;
  logic [REG_BUS-1:0] load_data;
  logic [REG_BUS-1:0] rdata_q;

  mem_lsu_align u_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_mem_addr[1:0]),
    .store_data (mem_reg2),
    .rdata      (dbus_rdata),
    .size       (size),
    .is_load    (is_load),
    .is_store   (is_store),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_data)
  );

  assign is_mem = (size != SZ_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault = ((size == SZ_HALF) && mem_mem_addr[0]) ||
                       ((size == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00));
  assign align_err   = rst && (state == ST_IDLE) && align_fault;
`else
  assign align_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem && !align_fault) begin
            state      <= ST_REQ;
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {mem_mem_addr[REG_BUS-1:2], 2'b00};
            dbus_be    <= be_c;
            dbus_wdata <= wdata_c;
          end
        end
        ST_REQ: begin
          if (dbus_ack) begin
            rdata_q  <= load_data;
            dbus_req <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst so stall and write-back drop immediately on reset even
  // while a memory op is still presented by EX/MEM.
  always_comb begin
    wb_wd        = '0;
    wb_wreg      = 1'b0;
    wb_wdata     = '0;
    stallreq_mem = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (!is_mem) begin
            wb_wd    = mem_wd;
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end else if (align_fault) begin
            wb_wd    = mem_wd;
            wb_wdata = mem_wdata;
          end else begin
            stallreq_mem = 1'b1;
          end
        end
        ST_REQ: stallreq_mem = 1'b1;
        ST_DONE: begin
          wb_wd    = mem_wd;
          wb_wreg  = is_load & mem_wreg;
          wb_wdata = is_load ? rdata_q : mem_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default build, plus the
// align-trap case when MEM_ALIGN_CHECK_EN is defined).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam logic [7:0] OP_OR = 8'b0010_0101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic        stallreq_mem;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned r_stall, r_req;
  logic [31:0] r_addr, r_bwdata, r_wb_wdata;
  logic [3:0]  r_be;
  logic [4:0]  r_wb_wd;
  logic        r_we, r_wb_wreg, r_stable;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .wb_wd        (wb_wd),
    .wb_wreg      (wb_wreg),
    .wb_wdata     (wb_wdata),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_rdata   (dbus_rdata),
    .dbus_ack     (dbus_ack),
    .stallreq_mem (stallreq_mem)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_err    (align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wdata    = wdata;
    mem_wd       = wd;
    mem_wreg     = wreg;
  endtask

  // Presents one memory op, acks after `waits` extra REQ cycles, and records
  // bus values, stability, stall/req cycle counts and the DONE-cycle wb outputs.
  task automatic run_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                            input int unsigned waits, input logic [31:0] rdata);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    drive(op, addr, reg2, 32'h0000_0055, 5'd9, 1'b1);
    dbus_ack = 1'b0;
    r_stall  = 0;
    r_req    = 0;
    r_stable = 1'b1;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (stallreq_mem) r_stall++;
      if (dbus_req) begin
        r_req++;
        if (r_req == 1) begin
          r_addr = dbus_addr; r_be = dbus_be; r_bwdata = dbus_wdata; r_we = dbus_we;
        end else if (dbus_addr !== r_addr || dbus_be !== r_be ||
                     dbus_wdata !== r_bwdata || dbus_we !== r_we) begin
          r_stable = 1'b0;
        end
      end
      if (!stallreq_mem) begin
        r_wb_wdata = wb_wdata;
        r_wb_wreg  = wb_wreg;
        r_wb_wd    = wb_wd;
        dbus_ack   = 1'b0;
        done       = 1'b1;
      end else if (dbus_req && r_req == waits + 1) begin
        dbus_ack   = 1'b1;
        dbus_rdata = rdata;
      end else begin
        dbus_ack = 1'b0;
      end
    end
    check_eq("access_completes", 32'(done), 32'd1);
  endtask

  initial begin
    drive(8'h00, '0, '0, '0, '0, 1'b0);
    dbus_ack   = 1'b0;
    dbus_rdata = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_req",    32'(dbus_req),     32'd0);
    check_eq("rst_we",     32'(dbus_we),      32'd0);
    check_eq("rst_addr",   dbus_addr,         32'd0);
    check_eq("rst_be",     32'(dbus_be),      32'd0);
    check_eq("rst_bwdata", dbus_wdata,        32'd0);
    check_eq("rst_wb_wd",  32'(wb_wd),        32'd0);
    check_eq("rst_wreg",   32'(wb_wreg),      32'd0);
    check_eq("rst_wdata",  wb_wdata,          32'd0);
    check_eq("rst_stall",  32'(stallreq_mem), 32'd0);
    rst = 1'b1;

    // Non-memory op passes straight through; a stray ack is ignored.
    @(posedge clk); #1;
    drive(OP_OR, 32'h0000_0100, 32'h0, 32'h1234_5678, 5'd5, 1'b1);
    dbus_ack = 1'b1;
    @(negedge clk);
    check_eq("alu_wd",    32'(wb_wd),        32'd5);
    check_eq("alu_wreg",  32'(wb_wreg),      32'd1);
    check_eq("alu_wdata", wb_wdata,          32'h1234_5678);
    check_eq("alu_stall", 32'(stallreq_mem), 32'd0);
    check_eq("alu_req",   32'(dbus_req),     32'd0);
    @(negedge clk);
    check_eq("idle_ack_req", 32'(dbus_req),  32'd0);
    dbus_ack = 1'b0;

    run_access(EXE_LW_OP, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    check_eq("lw_data",  r_wb_wdata,    32'hDEAD_BEEF);
    check_eq("lw_wreg",  32'(r_wb_wreg), 32'd1);
    check_eq("lw_wd",    32'(r_wb_wd),   32'd9);
    check_eq("lw_stall", r_stall,       32'd2);
    check_eq("lw_req",   r_req,         32'd1);
    check_eq("lw_addr",  r_addr,        32'h0000_0100);
    check_eq("lw_be",    32'(r_be),      32'hF);
    check_eq("lw_we",    32'(r_we),      32'd0);

    run_access(EXE_LB_OP, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
    check_eq("lb_data", r_wb_wdata, 32'hFFFF_FF80);
    check_eq("lb_be",   32'(r_be),   32'hF);
    run_access(EXE_LBU_OP, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
    check_eq("lbu_data", r_wb_wdata, 32'h0000_0080);
    run_access(EXE_LH_OP, 32'h0000_0102, 32'h0, 0, 32'h8001_7FFF);
    check_eq("lh_data", r_wb_wdata, 32'hFFFF_8001);
    run_access(EXE_LHU_OP, 32'h0000_0100, 32'h0, 0, 32'h8001_7FFF);
    check_eq("lhu_data", r_wb_wdata, 32'h0000_7FFF);

    run_access(EXE_SH_OP, 32'h0000_0102, 32'hAAAA_1234, 3, 32'h0);
    check_eq("sh_be",     32'(r_be),      32'hC);
    check_eq("sh_bwdata", r_bwdata,      32'h1234_1234);
    check_eq("sh_addr",   r_addr,        32'h0000_0100);
    check_eq("sh_we",     32'(r_we),      32'd1);
    check_eq("sh_stable", 32'(r_stable),  32'd1);
    check_eq("sh_req",    r_req,         32'd4);
    check_eq("sh_stall",  r_stall,       32'd5);
    check_eq("sh_wreg",   32'(r_wb_wreg), 32'd0);
    check_eq("sh_wdata",  r_wb_wdata,    32'h0000_0055);

    run_access(EXE_SB_OP, 32'h0000_0101, 32'h1234_56A5, 1, 32'h0);
    check_eq("sb_be",     32'(r_be),      32'h2);
    check_eq("sb_bwdata", r_bwdata,      32'hA5A5_A5A5);
    check_eq("sb_req",    r_req,         32'd2);
    check_eq("sb_wreg",   32'(r_wb_wreg), 32'd0);

    run_access(EXE_SW_OP, 32'h0000_020C, 32'hCAFE_F00D, 0, 32'h0);
    check_eq("sw_be",     32'(r_be),  32'hF);
    check_eq("sw_bwdata", r_bwdata,  32'hCAFE_F00D);
    check_eq("sw_addr",   r_addr,    32'h0000_020C);

`ifdef MEM_ALIGN_CHECK_EN
    @(posedge clk); #1;
    drive(EXE_LW_OP, 32'h0000_0102, 32'h0, 32'h0000_0055, 5'd9, 1'b1);
    @(negedge clk);
    check_eq("al_err",   32'(align_err),    32'd1);
    check_eq("al_req",   32'(dbus_req),     32'd0);
    check_eq("al_stall", 32'(stallreq_mem), 32'd0);
    check_eq("al_wreg",  32'(wb_wreg),      32'd0);
    @(posedge clk); #1;
    drive(OP_OR, 32'h0, 32'h0, 32'h0000_0001, 5'd1, 1'b1);
    @(negedge clk);
    check_eq("al_err_end", 32'(align_err), 32'd0);
    check_eq("al_req_end", 32'(dbus_req),  32'd0);
`else
    run_access(EXE_LW_OP, 32'h0000_0102, 32'h0, 0, 32'h1122_3344);
    check_eq("lw_mis_addr", r_addr,     32'h0000_0100);
    check_eq("lw_mis_data", r_wb_wdata, 32'h1122_3344);
    run_access(EXE_SH_OP, 32'h0000_0103, 32'h0000_BEEF, 0, 32'h0);
    check_eq("sh_mis_be",     32'(r_be),  32'hC);
    check_eq("sh_mis_bwdata", r_bwdata,  32'hBEEF_BEEF);
`endif

    // Asynchronous reset while a load is outstanding.
    @(posedge clk); #1;
    drive(EXE_LW_OP, 32'h0000_0100, 32'h0, 32'h0000_0055, 5'd9, 1'b1);
    dbus_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rreq_before", 32'(dbus_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rreq_async",   32'(dbus_req),     32'd0);
    check_eq("rstall_async", 32'(stallreq_mem), 32'd0);
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("rreq_late_ack", 32'(dbus_req), 32'd0);
    check_eq("rwreg_late_ack", 32'(wb_wreg), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("rel_stall_idle", 32'(stallreq_mem), 32'd1);
    check_eq("rel_req",        32'(dbus_req),     32'd0);
    check_eq("rel_wreg",       32'(wb_wreg),      32'd0);
    drive(OP_OR, 32'h0, 32'h0, 32'h0000_00A1, 5'd3, 1'b1);
    dbus_ack = 1'b0;
    @(negedge clk);
    check_eq("rel_alu_req",   32'(dbus_req), 32'd0);
    check_eq("rel_alu_wdata", wb_wdata,     32'h0000_00A1);

    run_access(EXE_LW_OP, 32'h0000_0104, 32'h0, 1, 32'h0BAD_F00D);
    check_eq("post_lw_data",  r_wb_wdata, 32'h0BAD_F00D);
    check_eq("post_lw_stall", r_stall,    32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
